// File: rtl/dts_conflict_check.sv
// Checks shifted difference vectors against an accumulated "used" bitmap.
// Tracks requests through the external shifter and drains before clearing.
module dts_conflict_check #(
  parameter int WIDTH   = 140,
  parameter int LATENCY = 10,
  parameter int TAG_W   = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  input  logic                             req_commit,
  input  logic [TAG_W-1:0]                 req_tag,
  input  logic [WIDTH-1:0]                 diff_vec,
  input  logic                             clear,
  output logic                             res_valid,
  output logic                             res_conflict,
  output logic [TAG_W-1:0]                 res_tag,
  output logic [WIDTH-1:0]                 res_overlap,
  output logic [WIDTH-1:0]                 used,
  output logic [15:0]                      commit_count,
  output logic [$clog2(LATENCY+2)-1:0]     in_flight,
  output logic                             idle
);
  localparam int IFW = $clog2(LATENCY+2);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;
  state_t state_q, state_d;

  logic [LATENCY-1:0]            vld_pipe;
  logic [LATENCY-1:0]            cmt_pipe;
  logic [LATENCY-1:0][TAG_W-1:0] tag_pipe;

  logic             launch, head_v, conflict, do_commit, clr;
  logic [WIDTH-1:0] overlap;

  assign launch    = req_valid && (state_q != DRAIN);
  assign head_v    = vld_pipe[LATENCY-1];
  assign overlap   = diff_vec & used;
  assign conflict  = |overlap;
  assign do_commit = head_v && cmt_pipe[LATENCY-1] && !conflict;
  // Zeroing happens on the edge where the pipeline is seen empty, and again in CLEAR.
  assign clr = (state_q == CLEAR) ||
               (state_q == RUN   && clear && in_flight == '0) ||
               (state_q == DRAIN && in_flight == '0);
  assign idle = (in_flight == '0) && (state_q == RUN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (clear && in_flight != '0) state_d = DRAIN;
      DRAIN:   if (in_flight == '0)          state_d = CLEAR;
      CLEAR:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      vld_pipe <= '0;
      cmt_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      state_q     <= state_d;
      vld_pipe[0] <= launch;
      cmt_pipe[0] <= req_commit;
      tag_pipe[0] <= req_tag;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        cmt_pipe[i] <= cmt_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid    <= 1'b0;
      res_conflict <= 1'b0;
      res_tag      <= '0;
      res_overlap  <= '0;
    end else begin
      res_valid <= head_v;
      if (head_v) begin
        res_conflict <= conflict;
        res_tag      <= tag_pipe[LATENCY-1];
        res_overlap  <= overlap;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      used         <= '0;
      commit_count <= '0;
    end else if (clr) begin
      used         <= '0;
      commit_count <= '0;
    end else if (do_commit) begin
      used <= used | diff_vec;
      if (commit_count != 16'hFFFF) commit_count <= commit_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_flight <= '0;
    end else begin
      unique case ({launch, res_valid})
        2'b10:   in_flight <= in_flight + IFW'(1);
        2'b01:   in_flight <= in_flight - IFW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end
endmodule

// File: tb/tb_dts_conflict_check.sv
// Bench for dts_conflict_check: shifter delay model, in-order scoreboard, scenario tasks.
module tb_dts_conflict_check;
  localparam int W   = 140;
  localparam int LAT = 10;
  localparam int TW  = 8;
  localparam int IFW = $clog2(LAT+2);

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid, req_commit, clear;
  logic [TW-1:0]  req_tag;
  logic [W-1:0]   req_dvec, diff_vec;
  logic           res_valid, res_conflict, idle;
  logic [TW-1:0]  res_tag;
  logic [W-1:0]   res_overlap, used;
  logic [15:0]    commit_count;
  logic [IFW-1:0] in_flight;

  int tests_run    = 0;
  int tests_failed = 0;
  int nres         = 0;

  typedef struct {
    logic [TW-1:0] tag;
    logic          conflict;
    logic [W-1:0]  overlap;
    logic [W-1:0]  used_after;
    logic [15:0]   count_after;
  } exp_t;
  exp_t sb[$];
  logic [W-1:0] m_used;
  logic [15:0]  m_cnt;

  always #5 clk = ~clk;

  dts_conflict_check #(.WIDTH(W), .LATENCY(LAT), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_commit(req_commit),
    .req_tag(req_tag), .diff_vec(diff_vec), .clear(clear),
    .res_valid(res_valid), .res_conflict(res_conflict), .res_tag(res_tag),
    .res_overlap(res_overlap), .used(used), .commit_count(commit_count),
    .in_flight(in_flight), .idle(idle)
  );

  // Stand-in for the pipelined shifter: diff_vec appears LAT cycles after launch.
  logic [W-1:0] shl [LAT];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) shl[i] <= '0;
    end else begin
      shl[0] <= req_dvec;
      for (int i = 1; i < LAT; i++) shl[i] <= shl[i-1];
    end
  end
  assign diff_vec = shl[LAT-1];

  always @(negedge clk) begin
    if (reset && res_valid) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_result: got tag=%h, required no result", res_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        nres++;
        if (res_tag !== e.tag || res_conflict !== e.conflict || res_overlap !== e.overlap ||
            used !== e.used_after || commit_count !== e.count_after) begin
          tests_failed++;
          $display("FAIL result: got tag=%h conf=%b ovl=%h used=%h cnt=%h; want tag=%h conf=%b ovl=%h used=%h cnt=%h",
                   res_tag, res_conflict, res_overlap, used, commit_count,
                   e.tag, e.conflict, e.overlap, e.used_after, e.count_after);
        end
      end
    end
  end

  function automatic logic [W-1:0] rvec();
    logic [W-1:0] v = '0;
    for (int i = 0; i < 5; i++) v = {v[W-33:0], 32'($urandom() & $urandom() & $urandom())};
    return v;
  endfunction

  task automatic send(input logic c, input logic [TW-1:0] tg, input logic [W-1:0] dv, input bit launch);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_commit = c; req_tag = tg; req_dvec = dv; clear = 1'b0;
    if (launch) begin
      e.tag      = tg;
      e.overlap  = dv & m_used;
      e.conflict = |e.overlap;
      if (c && !e.conflict) begin
        m_used = m_used | dv;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      e.used_after  = m_used;
      e.count_after = m_cnt;
      sb.push_back(e);
    end
  endtask

  task automatic nop();
    @(negedge clk);
    req_valid = 1'b0; req_commit = 1'b0; req_tag = '0; req_dvec = '0; clear = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    do begin nop(); k++; end while (!idle && k < lim);
    tests_run++;
    if (!idle) begin
      tests_failed++;
      $display("FAIL wait_idle: idle=%b in_flight=%0d after %0d cycles, required idle=1", idle, in_flight, k);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) nop();
    tests_run++;
    if (res_valid !== 0 || res_conflict !== 0 || res_tag !== '0 || res_overlap !== '0 ||
        used !== '0 || commit_count !== 0 || in_flight !== 0 || idle !== 1) begin
      tests_failed++;
      $display("FAIL reset_values: rv=%b cf=%b tag=%h used=%h cnt=%h inf=%0d idle=%b, required all zero and idle=1",
               res_valid, res_conflict, res_tag, used, commit_count, in_flight, idle);
    end
    reset = 1'b1;
    m_used = '0; m_cnt = '0;
    nop();
    tests_run++;
    if (idle !== 1'b1 || res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset: idle=%b rv=%b, required idle=1 rv=0", idle, res_valid);
    end
  endtask

  task automatic test_single_commit();
    int lat = 0;
    send(1'b1, 8'h3A, W'(5), 1'b1);
    for (int k = 1; k <= 20; k++) begin
      nop();
      if (res_valid && lat == 0) lat = k;
    end
    tests_run++;
    if (lat != LAT + 1) begin
      tests_failed++;
      $display("FAIL single_latency: got %0d cycles, required %0d", lat, LAT + 1);
    end
    tests_run++;
    if (used !== W'(5) || commit_count !== 16'd1 || idle !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_state: used=%h cnt=%0d idle=%b, required used=5 cnt=1 idle=1", used, commit_count, idle);
    end
  endtask

  task automatic test_clear_idle();
    @(negedge clk);
    req_valid = 1'b0; clear = 1'b1;
    nop();
    m_used = '0; m_cnt = '0;
    tests_run++;
    if (used !== '0 || commit_count !== 16'd0 || idle !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_idle: used=%h cnt=%0d idle=%b, required used=0 cnt=0 idle=1", used, commit_count, idle);
    end
  endtask

  task automatic test_back_to_back();
    send(1'b1, 8'h01, W'(6), 1'b1);
    send(1'b0, 8'h02, W'(4), 1'b1);
    wait_idle(30);
    tests_run++;
    if (used !== W'(6) || commit_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL back_to_back: used=%h cnt=%0d, required used=6 cnt=1", used, commit_count);
    end
  endtask

  task automatic test_full_rate();
    int peak = 0, base = nres, k = 0;
    for (int i = 0; i < 200; i++) begin
      send(1'($urandom_range(0, 1)), 8'($urandom()), rvec(), 1'b1);
      if (int'(in_flight) > peak) peak = int'(in_flight);
    end
    do begin
      nop(); k++;
      if (int'(in_flight) > peak) peak = int'(in_flight);
    end while (!idle && k < 40);
    tests_run++;
    if (peak != LAT + 1) begin
      tests_failed++;
      $display("FAIL full_rate_peak: got %0d, required %0d", peak, LAT + 1);
    end
    tests_run++;
    if (k != LAT + 2) begin
      tests_failed++;
      $display("FAIL full_rate_idle: got %0d cycles, required %0d", k, LAT + 2);
    end
    tests_run++;
    if (nres - base != 200) begin
      tests_failed++;
      $display("FAIL full_rate_count: got %0d results, required 200", nres - base);
    end
  endtask

  task automatic test_clear_busy();
    int k = 0;
    for (int i = 0; i < 3; i++) send(1'b1, 8'(8'h80 + i), rvec(), 1'b1);
    @(negedge clk);
    req_valid = 1'b0; clear = 1'b1;
    send(1'b1, 8'hEE, rvec(), 1'b0);
    send(1'b1, 8'hEF, rvec(), 1'b0);
    tests_run++;
    if (idle !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_idle: idle=%b, required 0 while draining", idle);
    end
    do begin nop(); k++; end while (in_flight != 0 && k < 30);
    m_used = '0; m_cnt = '0;
    nop();
    tests_run++;
    if (used !== '0 || commit_count !== 16'd0 || idle !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_busy: used=%h cnt=%0d idle=%b, required used=0 cnt=0 idle=0", used, commit_count, idle);
    end
    nop();
    tests_run++;
    if (idle !== 1'b1 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL clear_busy_end: idle=%b pending=%0d, required idle=1 pending=0", idle, sb.size());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) send(1'b1, 8'(8'h50 + i), W'(1) << i, 1'b1);
    nop();
    tests_run++;
    if (in_flight !== IFW'(5)) begin
      tests_failed++;
      $display("FAIL pre_reset_inflight: got %0d, required 5", in_flight);
    end
    #1 reset = 1'b0;
    #1;
    tests_run++;
    if (res_valid !== 0 || res_conflict !== 0 || res_tag !== '0 || res_overlap !== '0 ||
        used !== '0 || commit_count !== 0 || in_flight !== 0 || idle !== 1) begin
      tests_failed++;
      $display("FAIL async_reset: rv=%b used=%h cnt=%h inf=%0d idle=%b, required reset values",
               res_valid, used, commit_count, in_flight, idle);
    end
    reset = 1'b1;
    sb.delete();
    m_used = '0; m_cnt = '0;
    repeat (20) nop();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 65534; i++) send(1'b1, 8'(i), '0, 1'b1);
    for (int i = 0; i < 3; i++) send(1'b1, 8'hC0, W'(1) << (i * 40), 1'b1);
    wait_idle(40);
    tests_run++;
    if (commit_count !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL saturate: got %h, required FFFF", commit_count);
    end
    send(1'b1, 8'hC7, '0, 1'b1);
    wait_idle(40);
    tests_run++;
    if (commit_count !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL saturate_hold: got %h, required FFFF", commit_count);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_commit = 1'b0; req_tag = '0; req_dvec = '0; clear = 1'b0;
    m_used = '0; m_cnt = '0;
    test_reset();
    test_single_commit();
    test_clear_idle();
    test_back_to_back();
    test_full_rate();
    test_clear_busy();
    test_async_reset();
    test_saturation();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL leftover: %0d expected results never arrived", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/dts_conflict_check.md
# dts_conflict_check

Conflict checker that consumes the shifted difference vectors produced by the pipelined right shifter. It keeps an accumulated bitmap of differences already in use and checks each vector against it. It commits passing vectors on request and reports pass/conflict per request. It also tracks requests in flight through the shifter, so the search controller can pipeline candidates at one per cycle and learn when the pipeline has drained.

## Interface
- WIDTH, 140: difference bitmap width; must equal the shifter's WIDTH.
- LATENCY, 10: shifter latency in cycles; must equal the shifter's STAGES, minimum 1.
- TAG_W, 8: width of the request tag carried alongside each vector.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- req_valid  in  1  a request is launched this cycle; the shifter's `in`/`shift` must be driven in the same cycle.
- req_commit  in  1  OR the vector into the used bitmap if it passes.
- req_tag  in  TAG_W  opaque ID returned with the result.
- diff_vec  in  WIDTH  the shifter's `out`.
- clear  in  1  request to zero the used bitmap and counters.
- res_valid  out  1  result strobe, one cycle per request.
- res_conflict  out  1  result: 1 means the vector overlaps the used bitmap.
- res_tag  out  TAG_W  tag of the result.
- res_overlap  out  WIDTH  diff_vec & used at check time.
- used  out  WIDTH  current accumulated bitmap.
- commit_count  out  16  number of committed vectors; saturates at 16'hFFFF.
- in_flight  out  $clog2(LATENCY+2)  requests launched but not yet reported.
- idle  out  1  in_flight == 0 and state == RUN.

## Operation
- Delay line of LATENCY entries carries {valid, commit, tag}. An entry is written every cycle; its valid bit is req_valid.
- Check stage: when the delay-line head is valid, compute overlap = diff_vec & used and conflict = |overlap. Register both into res_*.
- Commit: if the head has commit=1 and conflict=0, then used <= used | diff_vec and commit_count increments, saturating, on the same edge.
- Checks happen in launch order at the check stage, so a commit is visible to the check of the very next result. No forwarding is needed.
- In-flight counter:
  - +1 on req_valid.
  - −1 on res_valid.
  - Both in the same cycle: no change.
  - It never exceeds LATENCY+1.
- State machine:
  - RUN: normal operation. `clear` with in_flight==0 zeroes used and commit_count on the next edge and stays in RUN. `clear` with in_flight!=0 goes to DRAIN.
  - DRAIN: req_valid is ignored and not launched (the controller must not issue). In-flight results still complete and may commit. When in_flight reaches 0, go to CLEAR.
  - CLEAR: used <= 0, commit_count <= 0, return to RUN. Lasts exactly one cycle.
- `clear` while in DRAIN or CLEAR is absorbed with no extra effect.
- A request with req_commit=0 is a probe: it is checked but never alters used.
- Bits of diff_vec above the shifted range are whatever the shifter supplies. They are checked like any other bit; there is no masking.

## Timing
- Reset (asynchronous, when reset is low) sets:
  - delay line valid bits = 0;
  - res_valid = 0, res_conflict = 0, res_tag = 0, res_overlap = 0;
  - used = 0, commit_count = 0, in_flight = 0;
  - state = RUN, idle = 1.
- Request at cycle t: the check stage sees diff_vec in cycle t+LATENCY. res_valid is high in cycle t+LATENCY+1. Total latency is LATENCY+1.
- used reflects a commit from cycle t+LATENCY+1 onward, the same cycle as its res_valid.
- Throughput is one request per cycle with no backpressure.
- Reset asserted mid-operation discards all in-flight requests; no res_valid is produced for them.
- The shifter must be reset together with this block, or its stale outputs are ignored via the delay-line valid bits.
- Clear with an empty pipeline: used reads 0 on the cycle after `clear`.
- Clear with a busy pipeline: used reads 0 one cycle after in_flight returns to 0.

## Test plan
- Single commit, LATENCY=10, WIDTH=140: req at t=5 with commit=1, tag=0x3A, diff_vec=0x5 at t=15 -> res_valid at t=16, conflict=0, tag=0x3A; used=0x5; commit_count=1.
- Back-to-back dependency: commit diff_vec=0x6 then, next cycle, probe diff_vec=0x4 -> first result conflict=0; second result conflict=1 with res_overlap=0x4; used stays 0x6.
- Full rate: 200 consecutive requests with random tags -> 200 res_valid pulses in order; in_flight peaks at 11; idle returns 12 cycles after the last request.
- Clear while busy: 3 requests in flight, clear pulsed -> DRAIN until all 3 results appear; requests issued during DRAIN produce no result; used=0 the cycle after in_flight hits 0.
- Async reset mid-flight: reset low for 1 ns between edges with 5 requests outstanding -> every output is immediately at its reset value; no res_valid appears for the 5 discarded requests.
- Saturation: force commit_count to 16'hFFFE, make 3 passing commits -> commit_count reads 16'hFFFF, then holds.
